// File: rtl/cnn_pkg.sv
// Shared width helpers, stage tag type and result shaping (ReLU / saturation)
// for the CNN kernel accumulator.
package cnn_pkg;

    localparam int WIDE_BW = 64;
    typedef logic signed [WIDE_BW-1:0] wide_t;

    // Control tag that travels alongside each pipeline stage.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } stage_tag_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // An unsigned fmap gets one extra bit so it can be multiplied as signed.
    function automatic int prod_bw(input int i_f_bw, input int w_bw, input int signed_fmap);
        return i_f_bw + w_bw + ((signed_fmap != 0) ? 0 : 1);
    endfunction

    function automatic int ksum_bw(input int p_bw, input int n);
        return p_bw + clog2(n);
    endfunction

    function automatic int acc_bw(input int ak_bw, input int ci);
        return ak_bw + clog2(ci) + 1;
    endfunction

    function automatic wide_t relu_w(input wide_t value, input int enable);
        return ((enable != 0) && (value < 0)) ? '0 : value;
    endfunction

    function automatic wide_t sat_w(input wide_t value, input int bw);
        wide_t hi;
        wide_t lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/cnn_kernel_acc_if.sv
// Stream interface of the kernel accumulator: input window beats in,
// signed results out, both under a valid/ready handshake.
interface cnn_kernel_acc_if #(
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int B_BW   = 16,
    parameter int O_BW   = 16
);
    logic                         i_clear;
    logic                         i_in_valid;
    logic                         o_in_ready;
    logic [KX*KY*I_F_BW-1:0]      i_in_fmap;
    logic [KX*KY*W_BW-1:0]        i_cnn_weight;
    logic [B_BW-1:0]              i_bias;
    logic                         o_ot_valid;
    logic                         i_ot_ready;
    logic signed [O_BW-1:0]       o_ot_kernel_acc;
    logic                         o_busy;

    modport master (
        output i_clear, i_in_valid, i_in_fmap, i_cnn_weight, i_bias, i_ot_ready,
        input  o_in_ready, o_ot_valid, o_ot_kernel_acc, o_busy
    );

    modport slave (
        input  i_clear, i_in_valid, i_in_fmap, i_cnn_weight, i_bias, i_ot_ready,
        output o_in_ready, o_ot_valid, o_ot_kernel_acc, o_busy
    );
endinterface

// File: rtl/cnn_adder_tree.sv
// Balanced binary adder tree over N signed inputs with a registered,
// enable-gated sum output.
module cnn_adder_tree
    import cnn_pkg::*;
#(
    parameter int N      = 25,
    parameter int IN_BW  = 17,
    parameter int OUT_BW = IN_BW + clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [N*IN_BW-1:0]       in_flat,
    output logic signed [OUT_BW-1:0] sum_q
);

    localparam int LEAVES = 1 << clog2(N);

    logic signed [OUT_BW-1:0] leaf [LEAVES];
    logic signed [OUT_BW-1:0] node [1:2*LEAVES-1];
    logic signed [OUT_BW-1:0] sum_d;

    genvar gi;
    generate
        for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < N) begin : g_used
                assign leaf[gi] = OUT_BW'($signed(in_flat[gi*IN_BW +: IN_BW]));
            end else begin : g_pad
                assign leaf[gi] = '0;
            end
        end
    endgenerate

    // Heap layout: node[i] = node[2i] + node[2i+1], leaves at LEAVES..2*LEAVES-1.
    always_comb begin
        for (int i = LEAVES; i < 2 * LEAVES; i++) begin
            node[i] = leaf[i - LEAVES];
        end
        for (int i = LEAVES - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        sum_d = en ? node[1] : sum_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

endmodule

// File: rtl/cnn_kernel_acc.sv
// Convolution kernel accumulator: multiplies one channel window per beat,
// sums it, accumulates CI channels, then adds bias and applies ReLU/saturation.
module cnn_kernel_acc
    import cnn_pkg::*;
#(
    parameter int KX          = 5,
    parameter int KY          = 5,
    parameter int CI          = 4,
    parameter int I_F_BW      = 8,
    parameter int W_BW        = 8,
    parameter int B_BW        = 16,
    parameter int O_BW        = 16,
    parameter int SIGNED_FMAP = 0,
    parameter int RELU        = 1
) (
    input logic            clk,
    input logic            reset_n,
    cnn_kernel_acc_if.slave bus
);

    localparam int N      = KX * KY;
    localparam int P_BW   = prod_bw(I_F_BW, W_BW, SIGNED_FMAP);
    localparam int AK_BW  = ksum_bw(P_BW, N);
    localparam int ACC_BW = acc_bw(AK_BW, CI);
    localparam int CNT_BW = (CI > 1) ? clog2(CI) : 1;
    localparam logic [CNT_BW-1:0] LAST_CH = CNT_BW'(CI - 1);

    logic                     advance;
    logic                     accept;
    logic [N*P_BW-1:0]        prod_comb;
    logic [N*P_BW-1:0]        prod_d, prod_q;
    logic [CNT_BW-1:0]        ch_d, ch_q;
    stage_tag_t               s1_d, s1_q, s2_d, s2_q;
    logic signed [AK_BW-1:0]  ksum_q;
    logic signed [ACC_BW-1:0] acc_sum;
    logic signed [ACC_BW-1:0] acc_d, acc_q;
    logic                     ot_valid_d, ot_valid_q;
    logic signed [O_BW-1:0]   ot_data_d, ot_data_q;

    // A full output register that is not being taken freezes every stage.
    assign advance = !ot_valid_q || bus.i_ot_ready;
    assign accept  = bus.i_in_valid && advance && !bus.i_clear;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mul
            logic signed [P_BW-1:0] f_ext;
            logic signed [P_BW-1:0] w_ext;
            if (SIGNED_FMAP != 0) begin : g_sf
                assign f_ext = P_BW'($signed(bus.i_in_fmap[gi*I_F_BW +: I_F_BW]));
            end else begin : g_uf
                assign f_ext = P_BW'(bus.i_in_fmap[gi*I_F_BW +: I_F_BW]);
            end
            assign w_ext = P_BW'($signed(bus.i_cnn_weight[gi*W_BW +: W_BW]));
            assign prod_comb[gi*P_BW +: P_BW] = f_ext * w_ext;
        end
    endgenerate

    cnn_adder_tree #(
        .N      (N),
        .IN_BW  (P_BW),
        .OUT_BW (AK_BW)
    ) u_tree (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (advance && s1_q.valid && !bus.i_clear),
        .in_flat (prod_q),
        .sum_q   (ksum_q)
    );

    always_comb begin
        ch_d       = ch_q;
        prod_d     = prod_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        acc_d      = acc_q;
        ot_valid_d = ot_valid_q;
        ot_data_d  = ot_data_q;
        acc_sum    = s2_q.first ? ACC_BW'(ksum_q) : acc_q + ACC_BW'(ksum_q);

        if (bus.i_clear) begin
            ch_d       = '0;
            acc_d      = '0;
            s1_d.valid = 1'b0;
            s2_d.valid = 1'b0;
            if (advance) ot_valid_d = 1'b0;
        end else if (advance) begin
            s1_d.valid = accept;
            if (accept) begin
                ch_d       = (ch_q == LAST_CH) ? '0 : ch_q + CNT_BW'(1);
                prod_d     = prod_comb;
                s1_d.first = (ch_q == '0);
                s1_d.last  = (ch_q == LAST_CH);
            end
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.first = s1_q.first;
                s2_d.last  = s1_q.last;
            end
            ot_valid_d = 1'b0;
            if (s2_q.valid) begin
                acc_d = acc_sum;
                if (s2_q.last) begin
                    ot_valid_d = 1'b1;
                    ot_data_d  = O_BW'(sat_w(relu_w(wide_t'(acc_sum)
                                       + wide_t'($signed(bus.i_bias)), RELU), O_BW));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q       <= '0;
            prod_q     <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            acc_q      <= '0;
            ot_valid_q <= 1'b0;
            ot_data_q  <= '0;
        end else begin
            ch_q       <= ch_d;
            prod_q     <= prod_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            acc_q      <= acc_d;
            ot_valid_q <= ot_valid_d;
            ot_data_q  <= ot_data_d;
        end
    end

    assign bus.o_in_ready      = advance;
    assign bus.o_ot_valid      = ot_valid_q;
    assign bus.o_ot_kernel_acc = ot_data_q;
    assign bus.o_busy          = (ch_q != '0) || s1_q.valid || s2_q.valid || ot_valid_q;

endmodule
